pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning PC and target width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset (WIDTH bits).
REQ-003 The block SHALL have parameter STACK_DEPTH, default 4, meaning return-address stack entries (power of 2, 2..16).
REQ-004 The block SHALL have port CLK  input  1  rising-edge clock, the only clock.
REQ-005 The block SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port Stall  input  1  hold PC and stack this cycle.
REQ-007 The block SHALL have port Branch  input  1  taken-branch request.
REQ-008 The block SHALL have port Jump  input  1  unconditional jump request.
REQ-009 The block SHALL have port Call  input  1  jump-and-link request.
REQ-010 The block SHALL have port Ret  input  1  return request.
REQ-011 The block SHALL have port Target  input  WIDTH  destination for Branch/Jump/Call.
REQ-012 The block SHALL have port PC  output  WIDTH  registered current PC.
REQ-013 The block SHALL have port PCPlus  output  WIDTH  combinational PC+1, modulo 2^WIDTH.
REQ-014 The block SHALL have port Depth  output  $clog2(STACK_DEPTH)+1  registered stack occupancy.
REQ-015 The block SHALL have ports Full, Empty  output  1 each  combinational Depth==STACK_DEPTH / Depth==0.
REQ-016 The block SHALL have ports Overflow, Underflow  output  1 each  registered sticky error flags.
REQ-017 The block SHALL have port Redirect  output  1  registered pulse, high the cycle after a non-sequential PC update.

Function
REQ-018 All state SHALL update only on rising CLK; PC SHALL change exactly one cycle after the request is sampled.
REQ-019 Next-PC priority SHALL be: Reset > Stall > Ret > Call > Jump > Branch > sequential (PC <= PCPlus).
REQ-020 Stall=1 SHALL hold PC, stack, Depth and flags, and SHALL drive Redirect to 0 next cycle; all requests that cycle are dropped.
REQ-021 Jump or Branch (winning) SHALL load PC <= Target and set Redirect=1 next cycle; stack unchanged.
REQ-022 Call with Full=0 SHALL push PCPlus, increment Depth, load PC <= Target, set Redirect.
REQ-023 Call with Full=1 SHALL load PC <= Target, leave stack and Depth unchanged (push discarded), set Overflow=1, set Redirect.
REQ-024 Ret with Empty=0 SHALL load PC <= top entry, pop (decrement Depth), set Redirect.
REQ-025 Ret with Empty=1 SHALL take the sequential path (PC <= PCPlus), set Underflow=1, Redirect=0.
REQ-026 Ret and Call asserted together SHALL act as Ret only; Call is dropped without flag change.
REQ-027 PC increment SHALL wrap from 2^WIDTH-1 to 0 with no flag; pushed PCPlus SHALL likewise be the wrapped value.
REQ-028 Overflow and Underflow SHALL remain set until Reset; no other clearing mechanism.
REQ-029 Stack SHALL be LIFO; entry contents beyond Depth are don't-care and SHALL not be observable.

Reset
REQ-030 Reset=1 at a rising edge SHALL set PC=RESET_VECTOR, Depth=0, Overflow=0, Underflow=0, Redirect=0, overriding Stall and all requests.
REQ-031 Reset mid-operation (any stack depth, any pending request) SHALL discard the stack; the first post-reset cycle SHALL be sequential unless a request is present.
REQ-032 Stack entry storage need not be reset.

Verification
REQ-033 Reset then 3 idle cycles, WIDTH=8 -> PC 0,1,2,3; Redirect=0; Empty=1.
REQ-034 PC=0xFF, idle cycle -> PC=0x00, no flags set.
REQ-035 PC=0x10, Call Target=0x40; then Ret -> PC 0x40 (Depth=1, Redirect=1), then 0x11 (Depth=0, Redirect=1).
REQ-036 STACK_DEPTH=4: 5 consecutive Calls to 0x20 from PC=0x00 -> Depth stays 4, Overflow=1 after 5th, PC=0x20; 4 Rets return 0x21,0x21,0x21,0x01.
REQ-037 Ret with Empty=1 at PC=0x05 -> PC=0x06, Underflow=1, persists until Reset.
REQ-038 Stall=1 with Jump=1 Target=0x80 at PC=0x07 -> PC stays 0x07; Reset+Stall+Call together -> PC=RESET_VECTOR, Depth=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer that includes a return-address stack.
//
// Each rising CLK edge selects the next PC. The priority order is:
//   Reset > Stall > Ret > Call > Jump/Branch > sequential (PC + 1)
// Call pushes PC + 1 onto a LIFO stack. Ret pops that stack.
// Overflow is set by a Call made while the stack is full.
// Underflow is set by a Ret made while the stack is empty.
// Both error flags stay set until the next Reset.
//
// Ports:
//   CLK        rising-edge clock
//   Reset      synchronous, active-high reset
//   Stall      hold all state this cycle; any request is dropped
//   Branch     taken-branch request    (PC <= Target)
//   Jump       unconditional jump      (PC <= Target)
//   Call       jump-and-link           (push PC+1, PC <= Target)
//   Ret        return                  (PC <= top of stack, pop)
//   Target     destination for Branch/Jump/Call
//   PC         registered current PC
//   PCPlus     combinational PC + 1, wraps modulo 2^WIDTH
//   Depth      registered stack occupancy
//   Full       combinational, Depth == STACK_DEPTH
//   Empty      combinational, Depth == 0
//   Overflow   sticky: a Call was made while Full
//   Underflow  sticky: a Ret was made while Empty
//   Redirect   high the cycle after a non-sequential PC update
module pc_sequencer #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STACK_DEPTH  = 4
) (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic                           Stall,
  input  logic                           Branch,
  input  logic                           Jump,
  input  logic                           Call,
  input  logic                           Ret,
  input  logic [WIDTH-1:0]               Target,
  output logic [WIDTH-1:0]               PC,
  output logic [WIDTH-1:0]               PCPlus,
  output logic [$clog2(STACK_DEPTH):0]   Depth,
  output logic                           Full,
  output logic                           Empty,
  output logic                           Overflow,
  output logic                           Underflow,
  output logic                           Redirect
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] DEPTH_MAX = STACK_DEPTH[AW:0];

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [AW:0]      depth_dec;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    push_idx;
  logic             push_en;

  assign PCPlus = PC + 1'b1;
  assign Full   = (Depth == DEPTH_MAX);
  assign Empty  = (Depth == '0);

  // The top entry sits at Depth-1 and the next free slot is at Depth.
  // When Depth == STACK_DEPTH the free-slot index would wrap. That case
  // is harmless because push_en is gated by Full.
  assign depth_dec = Depth - 1'b1;
  assign top_idx   = depth_dec[AW-1:0];
  assign push_idx  = Depth[AW-1:0];

  // A push happens only when Call wins arbitration and the stack has room.
  assign push_en = !Reset && !Stall && !Ret && Call && !Full;

  // The stack storage is not reset, so it can map onto plain registers
  // or a small RAM. Entries at or above Depth are never read.
  always_ff @(posedge CLK) begin
    if (push_en) begin
      stack_mem[push_idx] <= PCPlus;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      PC        <= RESET_VECTOR;
      Depth     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Redirect  <= 1'b0;
    end else if (Stall) begin
      Redirect  <= 1'b0;
    end else if (Ret) begin
      // Ret takes priority over Call, so a Call in the same cycle is ignored.
      if (!Empty) begin
        PC       <= stack_mem[top_idx];
        Depth    <= depth_dec;
        Redirect <= 1'b1;
      end else begin
        // A Ret on an empty stack falls through to the sequential path.
        PC        <= PCPlus;
        Underflow <= 1'b1;
        Redirect  <= 1'b0;
      end
    end else if (Call) begin
      if (!Full) begin
        Depth <= Depth + 1'b1;
      end else begin
        // The push is discarded when the stack is full, but the jump still happens.
        Overflow <= 1'b1;
      end
      PC       <= Target;
      Redirect <= 1'b1;
    end else if (Jump || Branch) begin
      PC       <= Target;
      Redirect <= 1'b1;
    end else begin
      PC       <= PCPlus;
      Redirect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer, using the default parameters
// (WIDTH=8, RESET_VECTOR=0, STACK_DEPTH=4).
// Directed stimulus drives both the DUT and a reference model.
// The model keeps the return stack in a queue.
// A single compare process checks every output at each falling edge.
// Literal checks pin the key sequences.
module tb_pc_sequencer;
  localparam int W  = 8;
  localparam int SD = 4;

  logic         CLK = 1'b0;
  logic         Reset, Stall, Branch, Jump, Call, Ret;
  logic [W-1:0] Target;
  logic [W-1:0] PC, PCPlus;
  logic [2:0]   Depth;
  logic         Full, Empty, Overflow, Underflow, Redirect;

  always #5 CLK = ~CLK;

  pc_sequencer #(.WIDTH(W), .RESET_VECTOR(8'h00), .STACK_DEPTH(SD)) dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch), .Jump(Jump),
    .Call(Call), .Ret(Ret), .Target(Target), .PC(PC), .PCPlus(PCPlus),
    .Depth(Depth), .Full(Full), .Empty(Empty), .Overflow(Overflow),
    .Underflow(Underflow), .Redirect(Redirect)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf, m_redir;
  bit model_valid = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_update(input bit rs, st, br, jp, cl, rt, input int tg);
    int nxt;
    nxt = (m_pc + 1) % 256;
    if (rs) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0; m_redir = 0;
    end else if (st) begin
      m_redir = 0;
    end else if (rt) begin
      if (m_stk.size() > 0) begin
        m_pc = m_stk.pop_back(); m_redir = 1;
      end else begin
        m_pc = nxt; m_unf = 1; m_redir = 0;
      end
    end else if (cl) begin
      if (m_stk.size() < SD) m_stk.push_back(nxt);
      else m_ovf = 1;
      m_pc = tg; m_redir = 1;
    end else if (jp || br) begin
      m_pc = tg; m_redir = 1;
    end else begin
      m_pc = nxt; m_redir = 0;
    end
  endfunction

  task automatic step(input bit rs, st, br, jp, cl, rt, input int tg);
    Reset = rs; Stall = st; Branch = br; Jump = jp; Call = cl; Ret = rt;
    Target = tg[W-1:0];
    @(posedge CLK);
    model_update(rs, st, br, jp, cl, rt, tg);
    #2;
  endtask

  task automatic idle();   step(0,0,0,0,0,0,0);  endtask
  task automatic rst();    step(1,0,0,0,0,0,0);  endtask
  task automatic jump(input int t); step(0,0,0,1,0,0,t); endtask
  task automatic call(input int t); step(0,0,0,0,1,0,t); endtask
  task automatic ret();    step(0,0,0,0,0,1,0);  endtask

  // The single compare process checks every output against the model.
  always @(negedge CLK) begin
    if (model_valid) begin
      chk("pc",        {24'h0, PC},       m_pc);
      chk("pcplus",    {24'h0, PCPlus},   (m_pc + 1) % 256);
      chk("depth",     {29'h0, Depth},    m_stk.size());
      chk("full",      {31'h0, Full},     (m_stk.size() == SD) ? 1 : 0);
      chk("empty",     {31'h0, Empty},    (m_stk.size() == 0) ? 1 : 0);
      chk("overflow",  {31'h0, Overflow}, {31'h0, m_ovf});
      chk("underflow", {31'h0, Underflow},{31'h0, m_unf});
      chk("redirect",  {31'h0, Redirect}, {31'h0, m_redir});
    end
  end

  initial begin
    Reset = 1; Stall = 0; Branch = 0; Jump = 0; Call = 0; Ret = 0; Target = '0;
    m_pc = 0; m_ovf = 0; m_unf = 0; m_redir = 0;
    rst();
    model_valid = 1'b1;
    chk("lit_reset_pc", {24'h0, PC}, 32'h00);
    chk("lit_reset_empty", {31'h0, Empty}, 32'h1);

    // Three idle cycles after reset.
    idle(); idle(); idle();
    chk("lit_idle_pc3", {24'h0, PC}, 32'h03);
    chk("lit_idle_redir", {31'h0, Redirect}, 32'h0);

    // PC wraps from 0xFF to 0x00.
    jump(8'hFF);
    idle();
    chk("lit_wrap_pc", {24'h0, PC}, 32'h00);
    chk("lit_wrap_flags", {30'h0, Overflow, Underflow}, 32'h0);

    // Call followed by Ret.
    jump(8'h10);
    call(8'h40);
    chk("lit_call_pc", {24'h0, PC}, 32'h40);
    chk("lit_call_depth", {29'h0, Depth}, 32'h1);
    ret();
    chk("lit_ret_pc", {24'h0, PC}, 32'h11);
    chk("lit_ret_redir", {31'h0, Redirect}, 32'h1);

    // Overflow case: five Calls are made into a stack of depth 4.
    rst();
    for (int i = 0; i < 5; i++) call(8'h20);
    chk("lit_ovf_depth", {29'h0, Depth}, 32'h4);
    chk("lit_ovf_flag", {31'h0, Overflow}, 32'h1);
    chk("lit_ovf_pc", {24'h0, PC}, 32'h20);
    ret(); chk("lit_ret1", {24'h0, PC}, 32'h21);
    ret(); chk("lit_ret2", {24'h0, PC}, 32'h21);
    ret(); chk("lit_ret3", {24'h0, PC}, 32'h21);
    ret(); chk("lit_ret4", {24'h0, PC}, 32'h01);

    // Underflow case: a Ret on an empty stack. The flag persists until Reset.
    rst();
    jump(8'h05);
    ret();
    chk("lit_unf_pc", {24'h0, PC}, 32'h06);
    chk("lit_unf_flag", {31'h0, Underflow}, 32'h1);
    chk("lit_unf_redir", {31'h0, Redirect}, 32'h0);
    idle(); idle(); call(8'h33); ret();
    chk("lit_unf_sticky", {31'h0, Underflow}, 32'h1);
    rst();
    chk("lit_unf_cleared", {31'h0, Underflow}, 32'h0);

    // Stall drops a Jump. Reset overrides Stall and Call.
    jump(8'h07);
    step(0,1,0,1,0,0,8'h80);
    chk("lit_stall_pc", {24'h0, PC}, 32'h07);
    chk("lit_stall_redir", {31'h0, Redirect}, 32'h0);
    call(8'h50);
    step(1,1,0,0,1,0,8'h60);
    chk("lit_rst_over_pc", {24'h0, PC}, 32'h00);
    chk("lit_rst_over_depth", {29'h0, Depth}, 32'h0);

    // A Call at 0xFF pushes the wrapped return address 0x00.
    jump(8'hFF);
    call(8'h30);
    ret();
    chk("lit_wrap_push", {24'h0, PC}, 32'h00);

    // Ret and Call together act as Ret only.
    call(8'h44);
    step(0,0,0,0,1,1,8'h99);
    chk("lit_retcall_pc", {24'h01, 8'h00} & 32'hFF | {24'h0, PC}, 32'h01);
    chk("lit_retcall_ovf", {31'h0, Overflow}, 32'h0);

    // Stall while the stack is in use, plus Branch and Jump priority.
    call(8'h10); call(8'h20);
    step(0,1,0,0,0,1,0);
    step(0,0,1,0,0,0,8'hA5);
    step(0,0,1,1,0,0,8'h5A);
    ret(); ret(); ret();
    idle();

    // Reset in the middle of operation, then the first cycle after it.
    call(8'h70); call(8'h71);
    rst();
    idle();
    chk("lit_post_rst_pc", {24'h0, PC}, 32'h01);

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
